// File: rtl/tc_fp_pkg.sv
// Shared FP32/BF16 field layout and pipeline payload types for the tensor-core
// FP output narrowing stages.
package tc_fp_pkg;

    localparam int FP32_W       = 32;
    localparam int BF16_W       = 16;
    localparam int EXP_W        = 8;
    localparam int FP32_FRAC_W  = 23;
    localparam int BF16_FRAC_W  = 7;
    localparam int FP32_SIGN    = 31;
    localparam int FP32_EXP_LSB = 23;
    localparam int RND_LSB      = FP32_W - BF16_W;  // bit 16: BF16 lsb
    localparam int RND_GUARD    = RND_LSB - 1;      // bit 15: first dropped bit

    localparam logic [BF16_FRAC_W-1:0] BF16_QNAN_FRAC = 7'h40;
    localparam logic [EXP_W-1:0]       EXP_MAX        = 8'hFF;

    // Only the upper half of the operand survives past classification.
    typedef struct packed {
        logic [BF16_W-1:0] op_hi;
        logic              nan;
        logic              rnd_up;
        logic              inexact;
    } s1_pay_t;

    typedef struct packed {
        logic [BF16_W-1:0] data;
        logic              inexact;
        logic              ovf;
        logic              nan;
    } s2_pay_t;

endpackage

// File: rtl/fp32_to_bf16_pipe_if.sv
// Input (FP32) and output (BF16) valid/ready streams of the narrowing stage.
interface fp32_to_bf16_pipe_if;
    import tc_fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP32_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BF16_W-1:0] out_data;
    logic              out_inexact;
    logic              out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact, out_ovf
    );

endinterface

// File: rtl/bf16_round.sv
// FP32->BF16 RNE logic, split into a classify half and a round half so a
// pipeline can register the decisions between them; tie both to one operand
// for a purely combinational converter.
module bf16_round
    import tc_fp_pkg::*;
(
    input  logic [FP32_W-1:0] cls_op_i,
    output logic              cls_nan_o,
    output logic              cls_rnd_up_o,
    output logic              cls_inexact_o,
    input  logic [BF16_W-1:0] rnd_hi_i,
    input  logic              rnd_nan_i,
    input  logic              rnd_up_i,
    output logic [BF16_W-1:0] res_o,
    output logic              ovf_o
);

    logic [EXP_W-1:0]       cls_exp;
    logic [FP32_FRAC_W-1:0] cls_frac;
    logic                   lsb, guard, sticky;
    logic [BF16_W-2:0]      mag_rnd;

    assign cls_exp  = cls_op_i[FP32_SIGN-1:FP32_EXP_LSB];
    assign cls_frac = cls_op_i[FP32_FRAC_W-1:0];
    assign lsb      = cls_op_i[RND_LSB];
    assign guard    = cls_op_i[RND_GUARD];
    assign sticky   = |cls_op_i[RND_GUARD-1:0];

    assign cls_nan_o     = (cls_exp == EXP_MAX) && (cls_frac != '0);
    assign cls_rnd_up_o  = ~cls_nan_o & guard & (sticky | lsb);
    assign cls_inexact_o = ~cls_nan_o & (guard | sticky);

    // Rounding on the 15-bit magnitude lets a fraction carry ripple into the
    // exponent (denormal->normal, next binade, max finite->inf).
    assign mag_rnd = rnd_hi_i[BF16_W-2:0] + {{(BF16_W-2){1'b0}}, rnd_up_i};

    always_comb begin
        res_o = {rnd_hi_i[BF16_W-1], mag_rnd};
        ovf_o = 1'b0;
        if (rnd_nan_i) begin
            res_o = {rnd_hi_i[BF16_W-1], EXP_MAX, BF16_QNAN_FRAC};
        end else begin
            ovf_o = (rnd_hi_i[BF16_W-2:BF16_FRAC_W] != EXP_MAX) &&
                    (mag_rnd[BF16_W-2:BF16_FRAC_W] == EXP_MAX);
        end
    end

endmodule

// File: rtl/fp32_to_bf16_pipe.sv
// Two-stage FP32->BF16 RNE narrowing pipeline with valid/ready on both sides,
// sticky status flags and a saturating transfer counter.
module fp32_to_bf16_pipe
    import tc_fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp32_to_bf16_pipe_if.slave   bus,
    input  logic                 clr_stat,
    output logic                 stat_inexact,
    output logic                 stat_ovf,
    output logic                 stat_nan,
    output logic [CNT_W-1:0]     xfer_cnt
);

    logic [2:1]       vld_pipe_q, vld_pipe_d;
    s1_pay_t          s1_q, s1_d;
    s2_pay_t          s2_q, s2_d;
    logic             adv1, adv2, xfer;
    logic             cls_nan, cls_rnd_up, cls_inexact;
    logic [BF16_W-1:0] rnd_res;
    logic             rnd_ovf;
    logic             st_inx_q, st_inx_d;
    logic             st_ovf_q, st_ovf_d;
    logic             st_nan_q, st_nan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // in_ready depends combinationally on out_ready so a full pipe moves as a unit.
    assign adv2         = ~vld_pipe_q[2] | bus.out_ready;
    assign adv1         = ~vld_pipe_q[1] | adv2;
    assign bus.in_ready = adv1;
    assign xfer         = vld_pipe_q[2] & bus.out_ready;

    bf16_round u_round (
        .cls_op_i      (bus.in_data),
        .cls_nan_o     (cls_nan),
        .cls_rnd_up_o  (cls_rnd_up),
        .cls_inexact_o (cls_inexact),
        .rnd_hi_i      (s1_q.op_hi),
        .rnd_nan_i     (s1_q.nan),
        .rnd_up_i      (s1_q.rnd_up),
        .res_o         (rnd_res),
        .ovf_o         (rnd_ovf)
    );

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        if (adv1) begin
            vld_pipe_d[1] = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = '{op_hi:   bus.in_data[FP32_W-1:RND_LSB],
                         nan:     cls_nan,
                         rnd_up:  cls_rnd_up,
                         inexact: cls_inexact};
            end
        end
        if (adv2) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                s2_d = '{data:    rnd_res,
                         inexact: s1_q.inexact,
                         ovf:     rnd_ovf,
                         nan:     s1_q.nan};
            end
        end
    end

    // Clear wins over a same-cycle transfer.
    always_comb begin
        st_inx_d = st_inx_q;
        st_ovf_d = st_ovf_q;
        st_nan_d = st_nan_q;
        cnt_d    = cnt_q;
        if (clr_stat) begin
            st_inx_d = 1'b0;
            st_ovf_d = 1'b0;
            st_nan_d = 1'b0;
            cnt_d    = '0;
        end else if (xfer) begin
            st_inx_d = st_inx_q | s2_q.inexact;
            st_ovf_d = st_ovf_q | s2_q.ovf;
            st_nan_d = st_nan_q | s2_q.nan;
            if (!(&cnt_q)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            st_inx_q   <= 1'b0;
            st_ovf_q   <= 1'b0;
            st_nan_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            st_inx_q   <= st_inx_d;
            st_ovf_q   <= st_ovf_d;
            st_nan_q   <= st_nan_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.out_valid   = vld_pipe_q[2];
    assign bus.out_data    = s2_q.data;
    assign bus.out_inexact = s2_q.inexact;
    assign bus.out_ovf     = s2_q.ovf;
    assign stat_inexact    = st_inx_q;
    assign stat_ovf        = st_ovf_q;
    assign stat_nan        = st_nan_q;
    assign xfer_cnt        = cnt_q;

endmodule

// File: tb/tb_fp32_to_bf16_pipe.sv
// Scoreboard bench for fp32_to_bf16_pipe: arithmetic RNE reference model,
// negedge monitor, directed specials plus randomized traffic with backpressure.
module tb_fp32_to_bf16_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_stat;
    logic        stat_inexact, stat_ovf, stat_nan;
    logic [15:0] xfer_cnt;
    logic        clr4;
    logic        st4_inx, st4_ovf, st4_nan;
    logic [3:0]  cnt4;

    fp32_to_bf16_pipe_if bus ();
    fp32_to_bf16_pipe_if bus4 ();

    always #5 clk = ~clk;

    fp32_to_bf16_pipe #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .clr_stat(clr_stat),
        .stat_inexact(stat_inexact), .stat_ovf(stat_ovf), .stat_nan(stat_nan),
        .xfer_cnt(xfer_cnt)
    );

    fp32_to_bf16_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .clr_stat(clr4),
        .stat_inexact(st4_inx), .stat_ovf(st4_ovf), .stat_nan(st4_nan),
        .xfer_cnt(cnt4)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        inx;
        logic        ovf;
        logic        nan;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic        m_inx, m_ovf, m_nan;
    int          m_cnt;
    logic        prev_hold;
    logic [17:0] prev_out;
    int          ordy_mode = 0;
    logic        ordy_man = 1'b0;
    logic        bp_done;
    logic [31:0] dir [0:9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: treat the magnitude as an integer, divide by 2^16, and round
    // the quotient half-to-even on the remainder.
    function automatic exp_t ref_cvt(input logic [31:0] x);
        exp_t        e;
        int unsigned mag, qt, rm;
        logic        up;
        mag = {1'b0, x[30:0]};
        qt  = mag / 65536;
        rm  = mag % 65536;
        e   = '0;
        if (mag > 32'h7F80_0000) begin
            e.data = {x[31], 15'h7FC0};
            e.nan  = 1'b1;
        end else begin
            up     = (rm > 32768) || (rm == 32768 && (qt % 2) == 1);
            qt     = qt + (up ? 1 : 0);
            e.data = {x[31], qt[14:0]};
            e.inx  = (rm != 0);
            e.ovf  = (mag < 32'h7F80_0000) && (qt >= 32'h7F80);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            1: r[15:0] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
            2: begin
                r[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'hFE;
                if ($urandom_range(0, 3) == 0) r[22:0] = '0;
            end
            3: r[30:23] = 8'h00;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ordy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 1) == 1);
            default: bus.out_ready = ordy_man;
        endcase
    end

    // Monitor: stats vs model, stall stability, push accepts, pop transfers.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_inx = 0; m_ovf = 0; m_nan = 0; m_cnt = 0;
            prev_hold = 0;
        end else begin
            chk("stat_inexact", stat_inexact, m_inx);
            chk("stat_ovf", stat_ovf, m_ovf);
            chk("stat_nan", stat_nan, m_nan);
            chk("xfer_cnt", xfer_cnt, m_cnt);
            if (prev_hold) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_stable", {bus.out_data, bus.out_inexact, bus.out_ovf}, prev_out);
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(ref_cvt(bus.in_data));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out: got %h expected no result", bus.out_data);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_inexact", bus.out_inexact, e.inx);
                    chk("out_ovf", bus.out_ovf, e.ovf);
                    m_inx |= e.inx;
                    m_ovf |= e.ovf;
                    m_nan |= e.nan;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (clr_stat) begin
                m_inx = 0; m_ovf = 0; m_nan = 0; m_cnt = 0;
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_out  = {bus.out_data, bus.out_inexact, bus.out_ovf};
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] d);
        int   n;
        logic a;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            a = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 200);
        if (!a) begin
            total++; bad++;
            $display("FAIL send_timeout: got in_ready=0 expected accept of %h", d);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.out_valid) && n < 500);
        if (n >= 500) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, n;
        logic [15:0] cnt0, dcnt;
        dir[0] = 32'h3F80_0000; dir[1] = 32'h3F80_8000; dir[2] = 32'h3F81_8000;
        dir[3] = 32'h3F80_8001; dir[4] = 32'h7F7F_FFFF; dir[5] = 32'hFF80_0000;
        dir[6] = 32'h7F80_0001; dir[7] = 32'hFFC1_2345; dir[8] = 32'h007F_FFFF;
        dir[9] = 32'h0000_0001;
        rst_n = 1'b1; clr_stat = 1'b0; clr4 = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_inexact", bus.out_inexact, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_stats", {stat_inexact, stat_ovf, stat_nan}, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // Saturation on the narrow counter instance.
        sync();
        for (int i = 0; i < 20; i++) begin
            bus4.in_valid = 1'b1;
            bus4.in_data  = $urandom;
            @(posedge clk);
            #1;
        end
        bus4.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt4", cnt4, 15);
        chk("sat_in_ready4", bus4.in_ready, 1);

        // Directed specials, back-to-back.
        sync();
        for (int i = 0; i < 10; i++) send(dir[i]);
        drain();
        chk("dir_stat_ovf", stat_ovf, 1);
        chk("dir_stat_nan", stat_nan, 1);
        chk("dir_stat_inexact", stat_inexact, 1);

        // Backpressure: four offered, out_ready low for four cycles.
        ordy_mode = 2; ordy_man = 1'b0; bp_done = 1'b0;
        sync();
        cnt0 = xfer_cnt;
        fork
            begin
                send(32'h3F80_8001); send(32'h4049_0FDB);
                send(32'hC2F7_8000); send(32'h3F81_8000);
                bp_done = 1'b1;
            end
        join_none
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc++;
            if (k >= 2) chk("bp_in_ready_low", bus.in_ready, 0);
        end
        chk("bp_accepted", acc, 2);
        ordy_man = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1);
        n = 0;
        while (!bp_done && n < 200) begin @(negedge clk); n++; end
        chk("bp_done", bp_done, 1);
        drain();
        dcnt = xfer_cnt - cnt0;
        chk("bp_xfer_delta", dcnt, 4);

        // clr_stat coinciding with an inexact transfer.
        ordy_man = 1'b0;
        sync();
        send(32'h3F80_8000);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.out_valid && n < 50);
        ordy_man = 1'b1;
        sync();
        clr_stat = 1'b1;
        sync();
        clr_stat = 1'b0;
        ordy_man = 1'b0;
        @(negedge clk);
        chk("clr_stat_inexact", stat_inexact, 0);
        chk("clr_xfer_cnt", xfer_cnt, 0);
        ordy_mode = 0;
        sync();
        send(32'h3F81_8000);
        drain();
        chk("after_clr_inexact", stat_inexact, 1);
        chk("after_clr_cnt", xfer_cnt, 1);

        // Random traffic with random backpressure and idle gaps.
        ordy_mode = 1;
        sync();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rand_op());
        end
        drain();

        // Reset with both stages full, then latency of a fresh operand.
        ordy_mode = 2; ordy_man = 1'b0;
        sync();
        send(32'h3F80_8001);
        send(32'h3F80_8001);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", bus.out_data, 0);
        chk("midrst_out_inexact", bus.out_inexact, 0);
        chk("midrst_xfer_cnt", xfer_cnt, 0);
        chk("midrst_stats", {stat_inexact, stat_ovf, stat_nan}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_idle_valid", bus.out_valid, 0);
        end
        sync();
        send(32'h4000_0000);
        @(negedge clk);
        chk("lat_edge1_valid", bus.out_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("lat_edge2_valid", bus.out_valid, 1);
        ordy_man = 1'b1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
